// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - serial reverse double-dabble BCD-to-binary converter
//
// Purpose:
//   Converts a packed BCD value to binary for threshold/ADC compares.
//   Reverse double-dabble: the BCD register is shifted right into the binary register.
//   After every shift except the last, each BCD digit >= 8 has 3 subtracted from it.
//   One digit is adjusted per ADJUST cycle, so a conversion takes
//   2N + 2D(N-1) + 1 clock edges from acceptance to the o_DV pulse.
//   Here N = 4*DECIMAL_DIGITS and D = DECIMAL_DIGITS.
//   An input with an illegal digit (> 9) is rejected without converting.
//
// Ports:
//   i_Clock     - single clock; all logic changes on the rising edge
//   i_Reset     - synchronous, active-high; aborts a running conversion
//   i_BCD       - packed BCD input, digit 0 in [3:0]; sampled only when i_Start is accepted
//   i_Start     - conversion request; accepted only while idle, ignored while busy
//   o_Binary    - low OUTPUT_WIDTH bits of the decimal value (0 on error)
//   o_Overflow  - decimal value >= 2**OUTPUT_WIDTH
//   o_Error     - some input digit was > 9
//   o_Busy      - high in every state except idle
//   o_DV        - one-cycle pulse; o_Binary/o_Overflow/o_Error are valid and held until the next pulse
//
// OUTPUT_WIDTH must not exceed 4*DECIMAL_DIGITS.

module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 12
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [4*DECIMAL_DIGITS-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_Overflow,
  output logic                        o_Error,
  output logic                        o_Busy,
  output logic                        o_DV
);

  localparam int D     = DECIMAL_DIGITS;
  localparam int N     = 4 * DECIMAL_DIGITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SHIFT       = 3'd1,
    S_CHECK_SHIFT = 3'd2,
    S_ADJUST      = 3'd3,
    S_CHECK_DIGIT = 3'd4,
    S_DONE        = 3'd5,
    S_ERR_WAIT    = 3'd6,
    S_ERR_DONE    = 3'd7
  } state_t;

  state_t                    state_q,    state_d;
  logic [N-1:0]              bcd_q,      bcd_d;
  logic [N-1:0]              bin_q,      bin_d;
  logic [CNT_W-1:0]          cnt_q,      cnt_d;
  logic [IDX_W-1:0]          idx_q,      idx_d;
  logic [OUTPUT_WIDTH-1:0]   binary_q,   binary_d;
  logic                      overflow_q, overflow_d;
  logic                      error_q,    error_d;
  logic                      dv_q,       dv_d;

  logic                      start_bad;
  logic                      ovf_bits;

  // True when any nibble of the candidate input is not a decimal digit.
  function automatic logic has_bad_digit(input logic [N-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign start_bad = has_bad_digit(i_BCD);

  // Any set bit above the output width means the value did not fit.
  if (OUTPUT_WIDTH < N) begin : g_ovf
    assign ovf_bits = |bin_q[N-1:OUTPUT_WIDTH];
  end else begin : g_no_ovf
    assign ovf_bits = 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      binary_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      binary_q   <= binary_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      dv_q       <= dv_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = start_bad ? S_ERR_WAIT : S_SHIFT;
        end
      end
      S_SHIFT:       state_d = S_CHECK_SHIFT;
      S_CHECK_SHIFT: state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADJUST;
      S_ADJUST:      state_d = S_CHECK_DIGIT;
      S_CHECK_DIGIT: state_d = (idx_q == IDX_LAST) ? S_SHIFT : S_ADJUST;
      S_DONE:        state_d = S_IDLE;
      // The rejected request spends one cycle here.
      // This keeps the error result two edges after acceptance.
      S_ERR_WAIT:    state_d = S_ERR_DONE;
      S_ERR_DONE:    state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Datapath updates and result capture.
  always_comb begin
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    dv_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          bcd_d = i_BCD;
          bin_d = '0;
          cnt_d = '0;
          idx_d = '0;
        end
      end

      S_SHIFT: begin
        // The BCD LSB moves into the binary MSB.
        // The binary value assembles LSB-first from the top down.
        bcd_d = bcd_q >> 1;
        bin_d = {bcd_q[0], bin_q[N-1:1]};
      end

      S_CHECK_SHIFT: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end

      S_ADJUST: begin
        // A digit >= 8 after a right shift carried a 1 down from its neighbour.
        // That 1 weighs 10/2 = 5 in this digit but reads as 8 in binary, hence -3.
        // The adjustment is nibble-local and never borrows across digits.
        for (int i = 0; i < D; i++) begin
          if (idx_q == IDX_W'(i) && bcd_q[4*i +: 4] >= 4'd8) begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] - 4'd3;
          end
        end
      end

      S_CHECK_DIGIT: begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      S_DONE: begin
        binary_d   = bin_q[OUTPUT_WIDTH-1:0];
        overflow_d = ovf_bits;
        error_d    = 1'b0;
        dv_d       = 1'b1;
      end

      S_ERR_DONE: begin
        binary_d   = '0;
        overflow_d = 1'b0;
        error_d    = 1'b1;
        dv_d       = 1'b1;
      end

      default: begin
      end
    endcase
  end

  // Output logic.
  always_comb begin
    o_Binary   = binary_q;
    o_Overflow = overflow_q;
    o_Error    = error_q;
    o_DV       = dv_q;
    o_Busy     = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - scoreboard bench for bcd_to_binary (12-bit and 14-bit outputs)

module tb_bcd_to_binary;

  typedef struct {
    logic [31:0] bin;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] bcd12, bcd14;
  logic        start12, start14;
  logic [11:0] bin12;
  logic [13:0] bin14;
  logic        ovf12, ovf14, err12, err14, busy12, busy14, dv12, dv14;

  int   n_cmp;
  int   n_err;
  int   cyc;
  int   acc_cyc;
  exp_t sb[$];

  bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(12)) dut12 (
    .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd12), .i_Start(start12),
    .o_Binary(bin12), .o_Overflow(ovf12), .o_Error(err12), .o_Busy(busy12), .o_DV(dv12)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) dut14 (
    .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd14), .i_Start(start14),
    .o_Binary(bin14), .o_Overflow(ovf14), .o_Error(err14), .o_Busy(busy14), .o_DV(dv14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_bin(input bit sel);
    return sel ? 32'(bin14) : 32'(bin12);
  endfunction

  function automatic logic get_ovf(input bit sel);
    return sel ? ovf14 : ovf12;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? err14 : err12;
  endfunction

  function automatic logic get_dv(input bit sel);
    return sel ? dv14 : dv12;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy14 : busy12;
  endfunction

  // Decimal reference model: decode the digits, then wrap to the output width.
  function automatic exp_t model(input logic [15:0] bcd, input int w);
    exp_t e;
    int   dec;
    int   d;
    bit   bad;
    dec = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      dec = dec * 10 + d;
    end
    e.err = bad;
    e.lat = bad ? 2 : 153;
    if (bad) begin
      e.bin = '0;
      e.ovf = 1'b0;
    end else begin
      e.bin = 32'(dec % (1 << w));
      e.ovf = (dec >= (1 << w));
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input bit sel, input string tag);
    check({tag, "_bin"},  get_bin(sel),         32'd0);
    check({tag, "_ovf"},  32'(get_ovf(sel)),    32'd0);
    check({tag, "_err"},  32'(get_err(sel)),    32'd0);
    check({tag, "_dv"},   32'(get_dv(sel)),     32'd0);
    check({tag, "_busy"}, 32'(get_busy(sel)),   32'd0);
  endtask

  // Start a request at the next cycle; returns at the negedge after the accepting edge.
  task automatic start_conv(input bit sel, input logic [15:0] bcd, input bit push);
    @(negedge clk);
    check("dv_low_before_start", 32'(get_dv(sel)), 32'd0);
    if (sel) begin
      bcd14   = bcd;
      start14 = 1'b1;
    end else begin
      bcd12   = bcd;
      start12 = 1'b1;
    end
    if (push) sb.push_back(model(bcd, sel ? 14 : 12));
    @(negedge clk);
    acc_cyc = cyc;
    start12 = 1'b0;
    start14 = 1'b0;
    check("busy_after_accept", 32'(get_busy(sel)), 32'd1);
  endtask

  // Wait for o_DV, then pop the scoreboard and compare latency and results.
  task automatic wait_dv(input bit sel, input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (!get_dv(sel) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb_empty: observed 0 entries expected 1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_dv_seen"}, 32'(get_dv(sel)), 32'd1);
    if (!get_dv(sel)) return;
    check({tag, "_latency"}, 32'(cyc - acc_cyc),  32'(e.lat));
    check({tag, "_bin"},     get_bin(sel),        e.bin);
    check({tag, "_ovf"},     32'(get_ovf(sel)),   32'(e.ovf));
    check({tag, "_err"},     32'(get_err(sel)),   32'(e.err));
  endtask

  task automatic run_conv(input bit sel, input logic [15:0] bcd, input string tag);
    start_conv(sel, bcd, 1'b1);
    wait_dv(sel, tag);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  initial begin
    int dv_count;
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    acc_cyc = 0;
    rst     = 1'b1;
    bcd12   = '0;
    bcd14   = '0;
    start12 = 1'b0;
    start14 = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero(1'b0, "reset12");
    check_outputs_zero(1'b1, "reset14");

    run_conv(1'b0, 16'h0000, "t1_zero");
    run_conv(1'b0, 16'h4095, "t2_4095");
    run_conv(1'b0, 16'h1234, "t2_1234");
    run_conv(1'b0, 16'h4094, "t2_4094");
    run_conv(1'b0, 16'h9999, "t3_9999");
    run_conv(1'b0, 16'h4096, "t3_4096");
    run_conv(1'b0, 16'h12A4, "t4_bad_mid");
    run_conv(1'b0, 16'h0042, "t4_clear");
    run_conv(1'b0, 16'hF000, "t4_bad_top");
    run_conv(1'b0, 16'h0009, "t4_after_bad");

    // A start during a running job is ignored.
    // An input change after acceptance has no effect on the result.
    start_conv(1'b0, 16'h1234, 1'b1);
    repeat (9) @(negedge clk);
    bcd12   = 16'h9999;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    bcd12   = 16'h0777;
    wait_dv(1'b0, "t5_ignored_start");

    // A reset mid-conversion aborts the request; no o_DV follows.
    start_conv(1'b0, 16'h9999, 1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero(1'b0, "t5_reset_abort");
    dv_count = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dv12) dv_count++;
    end
    check("t5_no_dv_after_abort", 32'(dv_count), 32'd0);
    run_conv(1'b0, 16'h0100, "t5_recover");

    // 14-bit instance: sweep plus boundaries, back-to-back with a one-cycle gap.
    run_conv(1'b1, 16'h0000, "t6_zero");
    run_conv(1'b1, 16'h9999, "t6_9999");
    run_conv(1'b1, 16'h8191, "t6_8191");
    run_conv(1'b1, 16'h8192, "t6_8192");
    for (int v = 1; v < 10000; v += 53) begin
      run_conv(1'b1, to_bcd(v), "t6_sweep");
    end
    for (int v = 9990; v < 10000; v++) begin
      run_conv(1'b1, to_bcd(v), "t6_top");
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
